// File: rtl/fifo_pkg.sv
// Shared sizing helpers and status-flag bit positions for param_fifo.
package fifo_pkg;

  localparam int ST_FULL   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_AFULL  = 2;
  localparam int ST_AEMPTY = 3;
  localparam int ST_W      = 4;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/param_fifo_if.sv
// Write/read handshake bundle for param_fifo.
interface param_fifo_if #(
  parameter int WIDTH = 32
);

  logic             w_valid;
  logic [WIDTH-1:0] data_in;
  logic             w_ready;
  logic             r_ready;
  logic [WIDTH-1:0] data_out;
  logic             r_valid;

  modport master (
    output w_valid,
    output data_in,
    output r_ready,
    input  w_ready,
    input  data_out,
    input  r_valid
  );

  modport slave (
    input  w_valid,
    input  data_in,
    input  r_ready,
    output w_ready,
    output data_out,
    output r_valid
  );

endinterface

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH storage: one synchronous write port, one async read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ptr_w(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [ptr_w(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]        rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Parameterised FIFO with sticky error flags.
// PARAM_FIFO_FWFT_EN selects first-word-fall-through reads.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 3,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  param_fifo_if.slave             bus,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    err_clr
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q;
  logic             unf_q;
  logic [ST_W-1:0]  status;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] rd_data;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    status            = '0;
    status[ST_FULL]   = (cnt_q == CW'(DEPTH));
    status[ST_EMPTY]  = (cnt_q == '0);
    status[ST_AFULL]  = (int'(cnt_q) >= AFULL_TH);
    status[ST_AEMPTY] = (int'(cnt_q) <= AEMPTY_TH);
  end

  assign push = bus.w_valid && !status[ST_FULL];
  assign pop  = bus.r_ready && !status[ST_EMPTY];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop)  rd_ptr <= inc(rd_ptr);
      unique case (1'b1)
        push && !pop: cnt_q <= cnt_q + CW'(1);
        pop && !push: cnt_q <= cnt_q - CW'(1);
        default:      cnt_q <= cnt_q;
      endcase
      // a new error event beats a same-cycle clear
      if (bus.w_valid && status[ST_FULL]) ovf_q <= 1'b1;
      else if (err_clr)                   ovf_q <= 1'b0;
      if (bus.r_ready && status[ST_EMPTY]) unf_q <= 1'b1;
      else if (err_clr)                    unf_q <= 1'b0;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push && !reset),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

`ifdef PARAM_FIFO_FWFT_EN
  assign bus.data_out = status[ST_EMPTY] ? '0 : rd_data;
  assign bus.r_valid  = !status[ST_EMPTY];
`else
  logic [WIDTH-1:0] dout_q;
  logic             rv_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
      rv_q   <= 1'b0;
    end else begin
      rv_q <= pop;
      if (pop) dout_q <= rd_data;
    end
  end

  assign bus.data_out = dout_q;
  assign bus.r_valid  = rv_q;
`endif

  assign bus.w_ready   = !status[ST_FULL];
  assign fifo_full     = status[ST_FULL];
  assign fifo_empty    = status[ST_EMPTY];
  assign almost_full   = status[ST_AFULL];
  assign almost_empty  = status[ST_AEMPTY];
  assign count         = cnt_q;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo at DEPTH=3 and DEPTH=5.
module tb_param_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       err_clr;
  logic       full3, empty3, afull3, aempty3;
  logic       ovf3, unf3;
  logic [1:0] count3;
  logic       full5, empty5, afull5, aempty5;
  logic       ovf5, unf5;
  logic [2:0] count5;
  int         n_checks = 0;
  int         n_fail   = 0;

  param_fifo_if #(.WIDTH(32)) bus3 ();
  param_fifo_if #(.WIDTH(32)) bus5 ();

  always #5 clk = ~clk;

  param_fifo #(.WIDTH(32), .DEPTH(3)) u_dut3 (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus3.slave),
    .fifo_full    (full3),
    .fifo_empty   (empty3),
    .almost_full  (afull3),
    .almost_empty (aempty3),
    .count        (count3),
    .overflow     (ovf3),
    .underflow    (unf3),
    .err_clr      (err_clr)
  );

  param_fifo #(.WIDTH(32), .DEPTH(5)) u_dut5 (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus5.slave),
    .fifo_full    (full5),
    .fifo_empty   (empty5),
    .almost_full  (afull5),
    .almost_empty (aempty5),
    .count        (count5),
    .overflow     (ovf5),
    .underflow    (unf5),
    .err_clr      (err_clr)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push3(input logic [31:0] d);
    bus3.w_valid = 1'b1;
    bus3.data_in = d;
    tick();
    bus3.w_valid = 1'b0;
  endtask

  task automatic pop3(input logic [31:0] exp);
`ifdef PARAM_FIFO_FWFT_EN
    check("pop_data", bus3.data_out, exp);
    check("pop_rv", bus3.r_valid, 1);
    bus3.r_ready = 1'b1;
    tick();
    bus3.r_ready = 1'b0;
`else
    bus3.r_ready = 1'b1;
    tick();
    bus3.r_ready = 1'b0;
    check("pop_data", bus3.data_out, exp);
    check("pop_rv", bus3.r_valid, 1);
`endif
  endtask

  initial begin
    reset        = 1'b1;
    err_clr      = 1'b0;
    bus3.w_valid = 1'b0;
    bus3.data_in = '0;
    bus3.r_ready = 1'b0;
    bus5.w_valid = 1'b0;
    bus5.data_in = '0;
    bus5.r_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();

    check("rst_empty", empty3, 1);
    check("rst_aempty", aempty3, 1);
    check("rst_count", count3, 0);
    check("rst_rvalid", bus3.r_valid, 0);
    check("rst_wready", bus3.w_ready, 1);
    check("rst_full", full3, 0);
    check("rst_afull", afull3, 0);
    check("rst_dout", bus3.data_out, 0);
    check("rst_ovf", ovf3, 0);

    // fill, overflow, drain in order
    for (int i = 0; i < 3; i++) begin
      push3(32'(i));
      check("fill_count", count3, 64'(i + 1));
    end
    check("full_flag", full3, 1);
    check("full_wready", bus3.w_ready, 0);
    check("full_afull", afull3, 1);
    check("full_aempty", aempty3, 0);
    push3(32'h3);
    check("ovf_set", ovf3, 1);
    check("ovf_count", count3, 3);
    pop3(32'h0);
    pop3(32'h1);
    pop3(32'h2);
    check("drain_count", count3, 0);
    tick();
`ifndef PARAM_FIFO_FWFT_EN
    check("drain_rv_low", bus3.r_valid, 0);
    check("drain_dout_hold", bus3.data_out, 32'h2);
`endif
    check("drain_unf", unf3, 0);

    // push+pop while full
    push3(32'h7);
    push3(32'h8);
    push3(32'h9);
    bus3.w_valid = 1'b1;
    bus3.data_in = 32'hA;
`ifdef PARAM_FIFO_FWFT_EN
    check("fpp_head", bus3.data_out, 32'h7);
`endif
    bus3.r_ready = 1'b1;
    tick();
    bus3.w_valid = 1'b0;
    bus3.r_ready = 1'b0;
    check("fpp_count", count3, 2);
`ifndef PARAM_FIFO_FWFT_EN
    check("fpp_dout", bus3.data_out, 32'h7);
`endif
    pop3(32'h8);
    pop3(32'h9);
    check("fpp_empty", empty3, 1);

    // push+pop while empty
    bus3.w_valid = 1'b1;
    bus3.data_in = 32'hB;
    bus3.r_ready = 1'b1;
    tick();
    bus3.w_valid = 1'b0;
    bus3.r_ready = 1'b0;
    check("epp_count", count3, 1);
    check("epp_unf", unf3, 1);
    check("epp_aempty", aempty3, 1);
`ifndef PARAM_FIFO_FWFT_EN
    check("epp_rv", bus3.r_valid, 0);
`endif
    pop3(32'hB);

    // sticky error clear and set-wins
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_ovf", ovf3, 0);
    check("clr_unf", unf3, 0);
    push3(32'h20);
    push3(32'h21);
    push3(32'h22);
    bus3.w_valid = 1'b1;
    err_clr      = 1'b1;
    tick();
    bus3.w_valid = 1'b0;
    check("setwin_ovf", ovf3, 1);
    tick();
    err_clr = 1'b0;
    check("clr2_ovf", ovf3, 0);
    pop3(32'h20);
    check("pre_rst_count", count3, 2);

    // reset mid-operation
    reset        = 1'b1;
    bus3.w_valid = 1'b1;
    bus3.r_ready = 1'b1;
    tick();
    reset        = 1'b0;
    bus3.w_valid = 1'b0;
    bus3.r_ready = 1'b0;
    check("mrst_count", count3, 0);
    check("mrst_empty", empty3, 1);
    check("mrst_rv", bus3.r_valid, 0);
    check("mrst_dout", bus3.data_out, 0);
    tick();
    check("mrst_count2", count3, 0);

    // single-word read timing
    push3(32'h55);
`ifdef PARAM_FIFO_FWFT_EN
    check("one_dout_pre", bus3.data_out, 32'h55);
    check("one_rv_pre", bus3.r_valid, 1);
    bus3.r_ready = 1'b1;
    tick();
    bus3.r_ready = 1'b0;
    check("one_rv_post", bus3.r_valid, 0);
`else
    check("one_rv_pre", bus3.r_valid, 0);
    bus3.r_ready = 1'b1;
    tick();
    bus3.r_ready = 1'b0;
    check("one_rv", bus3.r_valid, 1);
    check("one_dout", bus3.data_out, 32'h55);
    tick();
    check("one_rv_post", bus3.r_valid, 0);
    check("one_dout_hold", bus3.data_out, 32'h55);
`endif

    // DEPTH=5 streaming across pointer wrap
    bus5.w_valid = 1'b1;
    bus5.data_in = 32'h0FE;
    tick();
    bus5.data_in = 32'h0FF;
    tick();
    bus5.w_valid = 1'b0;
    check("d5_count", count5, 2);
    check("d5_afull", afull5, 0);
    check("d5_aempty", aempty5, 0);
    for (int i = 0; i < 12; i++) begin
      logic [31:0] exp;
      exp = 32'h0FE + 32'(i);
      bus5.w_valid = 1'b1;
      bus5.data_in = 32'h100 + 32'(i);
      bus5.r_ready = 1'b1;
`ifdef PARAM_FIFO_FWFT_EN
      check("d5_data", bus5.data_out, 64'(exp));
      tick();
`else
      tick();
      check("d5_data", bus5.data_out, 64'(exp));
      check("d5_rv", bus5.r_valid, 1);
`endif
      check("d5_pair_count", count5, 2);
    end
    bus5.w_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      logic [31:0] exp;
      exp = 32'h10A + 32'(i);
`ifdef PARAM_FIFO_FWFT_EN
      check("d5_tail", bus5.data_out, 64'(exp));
      tick();
`else
      tick();
      check("d5_tail", bus5.data_out, 64'(exp));
`endif
    end
    bus5.r_ready = 1'b0;
    check("d5_empty", empty5, 1);
    check("d5_unf", unf5, 0);
    check("d5_ovf", ovf5, 0);
    check("d5_full", full5, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
